ps2_key_event_ctrl: RTL

Controller that sequences the PS/2 keyboard receive path and turns raw scan-code bytes into complete key events for the home-simulation control logic. It samples `ps_clk`/`ps_data` on the 50 MHz system clock and deserialises and checks 11-bit frames. It resolves the `E0`, `F0` and `E1` prefix sequences into single make/break events. Events are buffered in a small FIFO behind a valid/ready handshake, so downstream logic never sees partial sequences or stale bytes.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_frame_rx.sv | 108 ++++++++++
 rtl/ps2_key_event_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, decoder states and event type for the PS/2 key path
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    // Keyboard housekeeping replies (BAT, ack, echo, resend, error) that never form key events.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchroniser, 11-bit frame deserialiser, frame check and timeout
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_parity,
    output logic       err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          err_parity_q, err_parity_d;
    logic          err_timeout_q, err_timeout_d;
    logic          fall;
    logic [10:0]   frame;

    always_comb begin
        clk_s1_d      = ps_clk;
        clk_s2_d      = clk_s1_q;
        clk_prev_d    = clk_s2_q;
        dat_s1_d      = ps_data;
        dat_s2_d      = dat_s1_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tmo_d         = tmo_q;
        byte_valid_d  = 1'b0;
        byte_data_d   = byte_data_q;
        err_parity_d  = 1'b0;
        err_timeout_d = 1'b0;
        fall          = clk_prev_q & ~clk_s2_q;
        // frame[0] = start, frame[8:1] = data, frame[9] = parity, frame[10] = stop
        frame         = {dat_s2_q, shift_q};

        if (fall) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!frame[0] && frame[10] && (^frame[9:1])) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = frame[8:1];
                end else begin
                    err_parity_d = 1'b1;
                end
            end else begin
                shift_d   = {dat_s2_q, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == T_LAST) begin
                tmo_d         = '0;
                bit_cnt_d     = 4'd0;
                err_timeout_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // ps_clk idles high, so its synchroniser and edge register reset high to avoid a false edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_prev_q    <= 1'b1;
            dat_s1_q      <= 1'b0;
            dat_s2_q      <= 1'b0;
            bit_cnt_q     <= 4'd0;
            shift_q       <= '0;
            tmo_q         <= '0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= 8'd0;
            err_parity_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            clk_prev_q    <= clk_prev_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tmo_q         <= tmo_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            err_parity_q  <= err_parity_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign err_parity  = err_parity_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 scan-code prefix decoder and key event FIFO
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       err_parity,
    output logic       err_timeout,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_err_parity;
    logic       rx_err_timeout;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
        .clk         (clk),
        .resetn      (resetn),
        .ps_clk      (ps_clk),
        .ps_data     (ps_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .err_parity  (rx_err_parity),
        .err_timeout (rx_err_timeout)
    );

    dec_state_e                   state_q, state_d;
    logic [2:0]                   skip_q, skip_d;
    logic                         emit_q, emit_d;
    ps2_event_t                   evt_q, evt_d;
    ps2_event_t [FIFO_DEPTH-1:0]  mem_q, mem_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                  count_q, count_d;
    logic                         overflow_q, overflow_d;
    logic                         push, pop, full, is_prefix;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        emit_d    = 1'b0;
        evt_d     = evt_q;
        is_prefix = (byte_data == PS2_EXT) || (byte_data == PS2_BRK);

        if (rx_err_parity || rx_err_timeout) begin
            state_d = ST_IDLE;
        end else if (byte_valid) begin
            evt_d.code = byte_data;
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (byte_data == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else if (byte_data == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else if (!is_ctrl_byte(byte_data)) begin
                        emit_d    = 1'b1;
                        evt_d.ext = 1'b0;
                        evt_d.rel = 1'b0;
                    end
                end
                ST_EXT: begin
                    if (byte_data == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_data != PS2_EXT) begin
                        state_d   = ST_IDLE;
                        emit_d    = 1'b1;
                        evt_d.ext = 1'b1;
                        evt_d.rel = 1'b0;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d   = ST_IDLE;
                    emit_d    = !is_prefix;
                    evt_d.ext = (state_q == ST_EXT_BRK);
                    evt_d.rel = 1'b1;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a new event when the head leaves in the same cycle.
    always_comb begin
        pop        = (count_q != '0) && evt_ready;
        full       = (count_q == FULL_CNT);
        push       = emit_q && (!full || pop);
        overflow_d = emit_q && full && !pop;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = evt_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            skip_q     <= 3'd0;
            emit_q     <= 1'b0;
            evt_q      <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            emit_q     <= emit_d;
            evt_q      <= evt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_valid   = (count_q != '0);
    assign evt_code    = mem_q[rd_ptr_q].code;
    assign evt_ext     = mem_q[rd_ptr_q].ext;
    assign evt_release = mem_q[rd_ptr_q].rel;
    assign err_parity  = rx_err_parity;
    assign err_timeout = rx_err_timeout;
    assign overflow    = overflow_q;

endmodule
